// File: rtl/cluster_pwr_seq.sv
// rtl/cluster_pwr_seq.sv - cluster power/clock/reset sequencer; optional drain timeout under CLUSTER_PWR_SEQ_TIMEOUT_EN
module cluster_pwr_seq #(
  parameter int PWR_CYCLES    = 16,
  parameter int RST_CYCLES    = 8,
  parameter int CNT_WIDTH     = 8,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pwr_req_i,
  input  logic        fetch_en_i,
  input  logic [63:0] boot_addr_i,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_byp_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o,
  output logic        pwr_ack_o,
  output logic [2:0]  state_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_CLK_ON  = 3'd2,
    ST_RST_REL = 3'd3,
    ST_ON      = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_CLK_OFF = 3'd6,
    ST_PWR_DN  = 3'd7
  } state_t;

  // A zero cycle count is treated as a single cycle.
  localparam logic [CNT_WIDTH-1:0] PWR_LOAD = CNT_WIDTH'((PWR_CYCLES == 0) ? 0 : PWR_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RST_LOAD = CNT_WIDTH'((RST_CYCLES == 0) ? 0 : RST_CYCLES - 1);

  state_t               r_state, w_next;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_pow, r_byp, r_clk_en, r_rstn, r_fetch, r_ack, r_timeout;
  logic [63:0]          r_boot;
  logic                 w_pow, w_byp, w_clk_en, w_rstn, w_fetch, w_ack, w_timeout;
  logic [63:0]          w_boot;

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  localparam logic [31:0] DRAIN_LAST = 32'((DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1);
  logic [31:0] r_drain_cnt;

  // Count cycles spent in DRAIN; restarts from zero on every DRAIN entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  r_drain_cnt <= '0;
    else if (r_state != ST_DRAIN) r_drain_cnt <= '0;
    else                          r_drain_cnt <= r_drain_cnt + 32'd1;
  end
`endif

  // State, counter and all outputs are registered together from the next-state decode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_OFF;
      r_cnt     <= '0;
      r_pow     <= 1'b0;
      r_byp     <= 1'b1;
      r_clk_en  <= 1'b0;
      r_rstn    <= 1'b0;
      r_fetch   <= 1'b0;
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
      r_boot    <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      r_pow     <= w_pow;
      r_byp     <= w_byp;
      r_clk_en  <= w_clk_en;
      r_rstn    <= w_rstn;
      r_fetch   <= w_fetch;
      r_ack     <= w_ack;
      r_timeout <= w_timeout;
      r_boot    <= w_boot;
    end
  end

  // Next state, counter reload on entry, and the output pattern of the state being entered.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = (r_cnt != '0) ? r_cnt - CNT_WIDTH'(1) : r_cnt;
    w_timeout = 1'b0;

    case (r_state)
      ST_OFF:     if (pwr_req_i)         w_next = ST_PWR_UP;
      ST_PWR_UP:  if (r_cnt == '0)       w_next = ST_CLK_ON;
      ST_CLK_ON:  if (r_cnt == '0)       w_next = ST_RST_REL;
      ST_RST_REL: if (r_cnt == '0)       w_next = ST_ON;
      ST_ON:      if (!pwr_req_i)        w_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!cluster_busy_i) begin
          w_next = ST_CLK_OFF;
        end
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
        else if (r_drain_cnt == DRAIN_LAST) begin
          w_next    = ST_CLK_OFF;
          w_timeout = 1'b1;
        end
`endif
      end
      ST_CLK_OFF: w_next = ST_PWR_DN;
      ST_PWR_DN:  if (r_cnt == '0)       w_next = ST_OFF;
      default:    w_next = ST_OFF;
    endcase

    if (w_next != r_state) begin
      case (w_next)
        ST_PWR_UP, ST_CLK_ON, ST_PWR_DN: w_cnt_nxt = PWR_LOAD;
        ST_RST_REL:                      w_cnt_nxt = RST_LOAD;
        default:                         w_cnt_nxt = r_cnt;
      endcase
    end

    w_pow    = (w_next != ST_OFF) && (w_next != ST_PWR_DN);
    w_clk_en = (w_next == ST_CLK_ON) || (w_next == ST_RST_REL) || (w_next == ST_ON) ||
               (w_next == ST_DRAIN) || (w_next == ST_CLK_OFF);
    w_rstn   = (w_next == ST_ON) || (w_next == ST_DRAIN);
    w_byp    = !w_rstn;
    w_ack    = (w_next == ST_ON);
    w_fetch  = (w_next == ST_ON) && fetch_en_i;
    // Boot address is sampled only on RST_REL entry and held until the next entry.
    w_boot   = ((w_next == ST_RST_REL) && (r_state != ST_RST_REL)) ? boot_addr_i : r_boot;
  end

  assign cluster_pow_o          = r_pow;
  assign cluster_byp_o          = r_byp;
  assign cluster_clk_en_o       = r_clk_en;
  assign cluster_rstn_o         = r_rstn;
  assign cluster_fetch_enable_o = r_fetch;
  assign cluster_boot_addr_o    = r_boot;
  assign pwr_ack_o              = r_ack;
  assign state_o                = r_state;
  assign timeout_o              = r_timeout;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// tb/tb_cluster_pwr_seq.sv - directed bench for cluster_pwr_seq
module tb_cluster_pwr_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwr_req = 1'b0;
  logic        fetch_en = 1'b0;
  logic [63:0] boot_addr = 64'd0;
  logic        busy = 1'b0;
  logic        pow, byp, clk_en, rstn, fetch, ack, tmo;
  logic [63:0] boot_o;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  cluster_pwr_seq #(
    .PWR_CYCLES(16), .RST_CYCLES(8), .CNT_WIDTH(8), .DRAIN_TIMEOUT(1024)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pwr_req_i(pwr_req), .fetch_en_i(fetch_en),
    .boot_addr_i(boot_addr), .cluster_busy_i(busy),
    .cluster_pow_o(pow), .cluster_byp_o(byp), .cluster_clk_en_o(clk_en),
    .cluster_rstn_o(rstn), .cluster_fetch_enable_o(fetch),
    .cluster_boot_addr_o(boot_o), .pwr_ack_o(ack), .state_o(state), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // state, pow, byp, clk_en, rstn, ack in one call
  task automatic outs(input string tag, input logic [2:0] s, input logic p, input logic b,
                      input logic c, input logic r, input logic a);
    check({tag, ".state"},  64'(state),  64'(s));
    check({tag, ".pow"},    64'(pow),    64'(p));
    check({tag, ".byp"},    64'(byp),    64'(b));
    check({tag, ".clk_en"}, 64'(clk_en), 64'(c));
    check({tag, ".rstn"},   64'(rstn),   64'(r));
    check({tag, ".ack"},    64'(ack),    64'(a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    outs("reset", 3'd0, 0, 1, 0, 0, 0);
    check("reset.fetch", 64'(fetch), 64'd0);
    check("reset.boot", boot_o, 64'd0);
    check("reset.tmo", 64'(tmo), 64'd0);
    rst_n = 1'b1;
    tick(1);
    check("idle.state", 64'(state), 64'd0);

    // power-up
    pwr_req = 1'b1; boot_addr = 64'h1C00_8080;
    tick(1);  outs("pwrup0", 3'd1, 1, 1, 0, 0, 0);
    tick(15); outs("pwrup15", 3'd1, 1, 1, 0, 0, 0);
    tick(1);  outs("clkon0", 3'd2, 1, 1, 1, 0, 0);
    tick(15); outs("clkon15", 3'd2, 1, 1, 1, 0, 0);
    tick(1);  outs("rstrel0", 3'd3, 1, 1, 1, 0, 0);
    check("rstrel.boot", boot_o, 64'h1C00_8080);
    tick(7);  outs("rstrel7", 3'd3, 1, 1, 1, 0, 0);
    tick(1);  outs("on", 3'd4, 1, 0, 1, 1, 1);
    check("on.fetch0", 64'(fetch), 64'd0);

    // boot address held and fetch follows request
    boot_addr = 64'd0; fetch_en = 1'b1;
    tick(1);  check("on.fetch1", 64'(fetch), 64'd1);
    tick(2);  check("on.boot_hold", boot_o, 64'h1C00_8080);

    // drain with busy for 50 cycles
    busy = 1'b1; pwr_req = 1'b0;
    tick(1);  outs("drain0", 3'd5, 1, 0, 1, 1, 0);
    check("drain.fetch", 64'(fetch), 64'd0);
    tick(49); check("drain49.state", 64'(state), 64'd5);
    busy = 1'b0;
    tick(1);  outs("clkoff", 3'd6, 1, 1, 1, 0, 0);
    tick(1);  outs("pwrdn0", 3'd7, 0, 1, 0, 0, 0);
    tick(15); check("pwrdn15.state", 64'(state), 64'd7);
    tick(1);  outs("off", 3'd0, 0, 1, 0, 0, 0);
    fetch_en = 1'b0;

    // request dropped during power-up: completes to ON, then powers down
    pwr_req = 1'b1; boot_addr = 64'hDEAD_BEEF_0000_1000;
    tick(1);  check("tog.pwrup", 64'(state), 64'd1);
    pwr_req = 1'b0;
    tick(39); check("tog.rstrel", 64'(state), 64'd3);
    tick(1);  outs("tog.on", 3'd4, 1, 0, 1, 1, 1);
    check("tog.boot", boot_o, 64'hDEAD_BEEF_0000_1000);
    tick(1);  check("tog.drain", 64'(state), 64'd5);
    tick(1);  check("tog.clkoff", 64'(state), 64'd6);
    tick(1);  check("tog.pwrdn", 64'(state), 64'd7);
    pwr_req = 1'b1;
    tick(15); check("tog.pwrdn15", 64'(state), 64'd7);
    tick(1);  check("tog.off", 64'(state), 64'd0);
    tick(1);  outs("tog.restart", 3'd1, 1, 1, 0, 0, 0);

    // async reset in RST_REL
    boot_addr = 64'h0000_0000_2000_0000;
    tick(32); check("ar.rstrel", 64'(state), 64'd3);
    check("ar.boot_new", boot_o, 64'h0000_0000_2000_0000);
    #2 rst_n = 1'b0;
    #1 outs("ar.async", 3'd0, 0, 1, 0, 0, 0);
    check("ar.boot", boot_o, 64'd0);
    tick(2);  check("ar.held", 64'(state), 64'd0);
    rst_n = 1'b1;
    tick(1);  outs("ar.restart", 3'd1, 1, 1, 0, 0, 0);

    // drain with busy stuck
    tick(40); check("stuck.on", 64'(state), 64'd4);
    busy = 1'b1; pwr_req = 1'b0;
    tick(1);  check("stuck.drain", 64'(state), 64'd5);
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
    tick(1023); check("to.drain1023", 64'(state), 64'd5);
    check("to.tmo_pre", 64'(tmo), 64'd0);
    tick(1);  check("to.clkoff", 64'(state), 64'd6);
    check("to.tmo", 64'(tmo), 64'd1);
    tick(1);  check("to.pwrdn", 64'(state), 64'd7);
    check("to.tmo_post", 64'(tmo), 64'd0);
`else
    tick(2000); check("notmo.drain", 64'(state), 64'd5);
    check("notmo.tmo", 64'(tmo), 64'd0);
    busy = 1'b0;
    tick(1);  check("notmo.clkoff", 64'(state), 64'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
